// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator (I/S/B/U/J/shamt) sign-extended to DATA_WIDTH, behind PIPE_STAGES elastic stages.
// Latency: PIPE_STAGES cycles from an accepted input to out_valid; one result per cycle while out_ready stays high.
// Backpressure: out_valid && !out_ready freezes the outputs, upstream stages fill, then in_ready drops (combinational from out_ready).
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   flush               drops every in-flight entry and any input offered in the same cycle
//   in_valid/in_ready   input handshake for instr + ImmSrc
//   instr, ImmSrc       raw instruction word and format select (000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 11x reserved)
//   out_valid/out_ready output handshake for ImmOp + illegal
//   ImmOp, illegal      extended immediate, reserved-format flag
module imm_gen_pipe #(
   parameter int INSTR_WIDTH = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int PIPE_STAGES = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic [2:0]             ImmSrc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  ImmOp,
   output logic                   illegal
);

   localparam logic [2:0] SRC_I     = 3'b000;
   localparam logic [2:0] SRC_S     = 3'b001;
   localparam logic [2:0] SRC_B     = 3'b010;
   localparam logic [2:0] SRC_U     = 3'b011;
   localparam logic [2:0] SRC_J     = 3'b100;
   localparam logic [2:0] SRC_SHAMT = 3'b101;

   // ------------------------------------------------------------------
   // Combinational extension
   // ------------------------------------------------------------------
   logic                  s;
   logic                  shamt_hi;
   logic [DATA_WIDTH-1:0] ext_imm;
   logic                  ext_ill;

   assign s = instr[31];
   // RV64 shift amounts are 6 bits wide; RV32 ignores instr[25].
   assign shamt_hi = (DATA_WIDTH == 64) ? instr[25] : 1'b0;

   always_comb begin
      ext_imm = '0;
      ext_ill = 1'b0;
      case (ImmSrc)
         SRC_I:     ext_imm = {{(DATA_WIDTH-12){s}}, instr[31:20]};
         SRC_S:     ext_imm = {{(DATA_WIDTH-12){s}}, instr[31:25], instr[11:7]};
         // instr[31] lands in bit 12 through the sign fill.
         SRC_B:     ext_imm = {{(DATA_WIDTH-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         SRC_U:     ext_imm = {{(DATA_WIDTH-31){s}}, instr[30:12], 12'b0};
         // instr[31] lands in bit 20 through the sign fill.
         SRC_J:     ext_imm = {{(DATA_WIDTH-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         SRC_SHAMT: ext_imm = {{(DATA_WIDTH-6){1'b0}}, shamt_hi, instr[24:20]};
         default:   ext_ill = 1'b1;
      endcase
   end

   // Opcode bits never contribute to an immediate.
   logic unused_instr;
   assign unused_instr = ^instr[6:0];

   // ------------------------------------------------------------------
   // Elastic pipeline
   // ------------------------------------------------------------------
   logic [PIPE_STAGES-1:0] vld_q;
   logic [PIPE_STAGES-1:0] ill_q;
   logic [DATA_WIDTH-1:0]  imm_q [PIPE_STAGES];

   logic [PIPE_STAGES-1:0] cap;     // stage k loads new data this edge
   logic [PIPE_STAGES-1:0] hand;    // stage k passes its entry on this edge
   logic [PIPE_STAGES-1:0] d_ill;
   logic [DATA_WIDTH-1:0]  d_imm [PIPE_STAGES];

   logic rdy_tail;   // last stage can take a new entry
   logic rdy_head;   // stage 0 can take a new entry

   assign rdy_tail = !vld_q[PIPE_STAGES-1] || out_ready;

   if (PIPE_STAGES == 1) begin : g_head_is_tail
      assign rdy_head = rdy_tail;
   end else begin : g_head_two
      assign rdy_head = !vld_q[0] || rdy_tail;
   end

   assign in_ready = rdy_head;

   // With at most two stages, the stage behind any non-last stage is the last one.
   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_src_in
         assign cap[k]   = in_valid && rdy_head;
         assign d_imm[k] = ext_imm;
         assign d_ill[k] = ext_ill;
      end else begin : g_src_prev
         assign cap[k]   = vld_q[k-1] && rdy_tail;
         assign d_imm[k] = imm_q[k-1];
         assign d_ill[k] = ill_q[k-1];
      end

      if (k == PIPE_STAGES-1) begin : g_hand_out
         assign hand[k] = vld_q[k] && out_ready;
      end else begin : g_hand_next
         assign hand[k] = vld_q[k] && rdy_tail;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         ill_q <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            imm_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            // A stage that hands off and captures in the same edge stays valid.
            if (flush) begin
               vld_q[k] <= 1'b0;
            end else if (cap[k]) begin
               vld_q[k] <= 1'b1;
            end else if (hand[k]) begin
               vld_q[k] <= 1'b0;
            end
            // Data only moves on a real capture; a flushed input leaves no trace.
            if (cap[k] && !flush) begin
               imm_q[k] <= d_imm[k];
               ill_q[k] <= d_ill[k];
            end
         end
      end
   end

   assign out_valid = vld_q[PIPE_STAGES-1];
   assign ImmOp     = imm_q[PIPE_STAGES-1];
   assign illegal   = ill_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: two imm_gen_pipe instances (32-bit/1 stage and 64-bit/2 stages) on shared stimulus.
// Every cycle both are compared against a timestamped in-flight queue and an arithmetic immediate model.
// Directed sections cover the listed formats, backpressure, flush and reset; a random section follows.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] instr;
   logic [2:0]  src;

   logic        a_in_ready, a_out_valid, a_illegal;
   logic [31:0] a_imm;
   logic        b_in_ready, b_out_valid, b_illegal;
   logic [63:0] b_imm;

   imm_gen_pipe #(.INSTR_WIDTH(32), .DATA_WIDTH(32), .PIPE_STAGES(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .instr(instr), .ImmSrc(src),
      .out_valid(a_out_valid), .out_ready(out_ready), .ImmOp(a_imm), .illegal(a_illegal)
   );

   imm_gen_pipe #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .PIPE_STAGES(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr), .ImmSrc(src),
      .out_valid(b_out_valid), .out_ready(out_ready), .ImmOp(b_imm), .illegal(b_illegal)
   );

   typedef struct {
      logic [63:0] imm;
      logic        ill;
      int          t;     // cycle index at which the entry was accepted
   } ent_t;

   ent_t qa[$];
   ent_t qb[$];
   ent_t none;
   int   cyc;
   int   n_tests;
   int   n_fail;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Immediate as a signed number built from field weights; result is {illegal, value}.
   function automatic logic [64:0] ref_imm(input logic [31:0] w, input logic [2:0] sel, input int dw);
      longint sgn;
      longint v;
      logic   ill;
      sgn = longint'(w[31]);
      v   = 0;
      ill = 1'b0;
      case (sel)
         3'd0: v = longint'(w[30:20]) - sgn * 2048;
         3'd1: v = longint'(w[30:25]) * 32 + longint'(w[11:7]) - sgn * 2048;
         3'd2: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2 - sgn * 4096;
         3'd3: v = longint'(w[30:12]) * 4096 - sgn * 64'sd2147483648;
         3'd4: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                   - sgn * 64'sd1048576;
         3'd5: v = (dw == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
         default: ill = 1'b1;
      endcase
      if (dw == 32) v = v & 64'sh0000_0000_FFFF_FFFF;
      return {ill, v};
   endfunction

   // Expected handshake for one instance: room while fewer than p entries are
   // held (or the head leaves), head visible p cycles after acceptance.
   task automatic check_one(input string n, input int p, input int qn, input ent_t head,
                            input logic ir, input logic ov, input logic [63:0] imm, input logic ill,
                            output logic acc, output logic pop);
      logic ir_e, ov_e;
      ir_e = (qn < p) || out_ready;
      ov_e = (qn > 0) && (head.t + p <= cyc);
      chk({n, "_in_ready"}, 64'(ir), 64'(ir_e));
      chk({n, "_out_valid"}, 64'(ov), 64'(ov_e));
      if (ov_e) begin
         chk({n, "_imm"}, imm, head.imm);
         chk({n, "_illegal"}, 64'(ill), 64'(head.ill));
      end
      acc = in_valid && ir_e;
      pop = ov_e && out_ready;
   endtask

   // One clock: check at negedge, update the model at posedge, return #1 later.
   task automatic cycle();
      logic acc_a, pop_a, acc_b, pop_b;
      ent_t ha, hb;
      logic [64:0] r;
      acc_a = 1'b0; pop_a = 1'b0; acc_b = 1'b0; pop_b = 1'b0;
      @(negedge clk);
      if (rst_n) begin
         ha = (qa.size() > 0) ? qa[0] : none;
         hb = (qb.size() > 0) ? qb[0] : none;
         check_one("a", 1, qa.size(), ha, a_in_ready, a_out_valid, {32'b0, a_imm}, a_illegal, acc_a, pop_a);
         check_one("b", 2, qb.size(), hb, b_in_ready, b_out_valid, b_imm, b_illegal, acc_b, pop_b);
      end
      @(posedge clk);
      if (!rst_n || flush) begin
         qa.delete();
         qb.delete();
      end else begin
         if (pop_a) void'(qa.pop_front());
         if (pop_b) void'(qb.pop_front());
         if (acc_a) begin
            r = ref_imm(instr, src, 32);
            qa.push_back('{imm: r[63:0], ill: r[64], t: cyc});
         end
         if (acc_b) begin
            r = ref_imm(instr, src, 64);
            qb.push_back('{imm: r[63:0], ill: r[64], t: cyc});
         end
      end
      cyc++;
      #1;
   endtask

   task automatic send(input logic [31:0] w, input logic [2:0] s);
      in_valid = 1'b1;
      instr    = w;
      src      = s;
      cycle();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      cycle();
   endtask

   initial begin
      none      = '{imm: 64'd0, ill: 1'b0, t: 0};
      cyc       = 0;
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      instr     = 32'd0;
      src       = 3'd0;

      // Reset state
      cycle();
      cycle();
      chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_imm", {32'b0, a_imm}, 64'd0);
      chk("rst_a_illegal", 64'(a_illegal), 64'd0);
      chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
      chk("rst_b_imm", b_imm, 64'd0);
      rst_n = 1'b1;
      idle();

      // All formats back to back; A shows each one edge later, B two edges later
      send(32'hFFF00093, 3'b000);
      chk("I32_valid", 64'(a_out_valid), 64'd1);
      chk("I32_imm", {32'b0, a_imm}, 64'h0000_0000_FFFF_FFFF);
      chk("I32_illegal", 64'(a_illegal), 64'd0);
      chk("I64_latency", 64'(b_out_valid), 64'd0);
      send(32'h0020A423, 3'b001);
      chk("S32_imm", {32'b0, a_imm}, 64'h0000_0000_0000_0008);
      chk("I64_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      send(32'hFE000EE3, 3'b010);
      chk("B32_imm", {32'b0, a_imm}, 64'h0000_0000_FFFF_FFFC);
      chk("S64_imm", b_imm, 64'h0000_0000_0000_0008);
      send(32'h123450B7, 3'b011);
      chk("U32_imm", {32'b0, a_imm}, 64'h0000_0000_1234_5000);
      chk("B64_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      send(32'h008000EF, 3'b100);
      chk("J32_imm", {32'b0, a_imm}, 64'h0000_0000_0000_0008);
      send(32'h800000B7, 3'b011);
      chk("U32_neg_imm", {32'b0, a_imm}, 64'h0000_0000_8000_0000);
      send(32'h03F00013, 3'b101);
      chk("shamt32_imm", {32'b0, a_imm}, 64'h0000_0000_0000_001F);
      chk("U64_neg_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
      send(32'h00000000, 3'b110);
      chk("rsvd32_imm", {32'b0, a_imm}, 64'd0);
      chk("rsvd32_illegal", 64'(a_illegal), 64'd1);
      chk("shamt64_imm", b_imm, 64'h0000_0000_0000_003F);
      idle();
      chk("rsvd64_imm", b_imm, 64'd0);
      chk("rsvd64_illegal", 64'(b_illegal), 64'd1);
      idle();
      idle();

      // Backpressure: B takes two, refuses the third, holds, then drains in order
      out_ready = 1'b0;
      send(32'hFFF00093, 3'b000);
      send(32'h0020A423, 3'b001);
      in_valid = 1'b1;
      instr    = 32'h123450B7;
      src      = 3'b011;
      #1;
      chk("bp_b_in_ready_full", 64'(b_in_ready), 64'd0);
      chk("bp_b_head", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      cycle();
      cycle();
      chk("bp_b_hold_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("bp_b_hold_valid", 64'(b_out_valid), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle();
      chk("bp_drain_second", b_imm, 64'h0000_0000_0000_0008);
      chk("bp_drain_second_valid", 64'(b_out_valid), 64'd1);
      cycle();
      chk("bp_drain_empty", 64'(b_out_valid), 64'd0);

      // Flush with two in flight plus a new input in the same cycle
      out_ready = 1'b0;
      send(32'hFFF00093, 3'b000);
      send(32'h0020A423, 3'b001);
      flush     = 1'b1;
      out_ready = 1'b1;
      send(32'h123450B7, 3'b011);
      flush = 1'b0;
      chk("flush_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("flush_b_out_valid", 64'(b_out_valid), 64'd0);
      send(32'h008000EF, 3'b100);
      chk("post_flush_a_imm", {32'b0, a_imm}, 64'h0000_0000_0000_0008);
      idle();
      chk("post_flush_b_imm", b_imm, 64'h0000_0000_0000_0008);
      chk("post_flush_b_valid", 64'(b_out_valid), 64'd1);
      idle();
      idle();

      // Reset in the middle of a stall with an illegal entry at A's output
      out_ready = 1'b0;
      send(32'h00000000, 3'b110);
      send(32'hFFF00093, 3'b000);
      in_valid = 1'b0;
      chk("pre_rst_a_illegal", 64'(a_illegal), 64'd1);
      rst_n = 1'b0;
      cycle();
      chk("mid_rst_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("mid_rst_a_imm", {32'b0, a_imm}, 64'd0);
      chk("mid_rst_a_illegal", 64'(a_illegal), 64'd0);
      chk("mid_rst_b_out_valid", 64'(b_out_valid), 64'd0);
      chk("mid_rst_b_imm", b_imm, 64'd0);
      chk("mid_rst_b_illegal", 64'(b_illegal), 64'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      idle();

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         instr     = $urandom;
         src       = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst_n     = ($urandom_range(0, 199) != 0);
         cycle();
      end
      flush     = 1'b0;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
